// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs op descriptors into I/S/B/R words and writes them to instruction memory.
// Optional macro IMM_RANGE_CHECK_EN rejects out-of-range or odd-offset immediates as illegal ops.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic signed [31:0]    in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [3:0] OP_ADDI = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_BNE  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   CAP  = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t      state, state_nxt;
  logic        last_p1;
  logic        hs, full, legal, sess_start;
  logic [31:0] word;

  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [12:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      OP_ADDI: w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      OP_LW:   w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      OP_BNE:  w = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      OP_ADD:  w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_SUB:  w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_AND:  w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      OP_OR:   w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      default: w = '0;
    endcase
    return w;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  function automatic logic imm_legal(input logic [3:0] op, input logic signed [31:0] imm);
    case (op)
      OP_ADDI, OP_LW, OP_SW: return (imm >= -32'sd2048) && (imm <= 32'sd2047);
      OP_BEQ, OP_BNE:        return (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      default:               return 1'b1;
    endcase
  endfunction

  assign legal = (in_op <= OP_OR) && imm_legal(in_op, in_imm);
`else
  // Upper immediate bits are truncated away when range checking is disabled.
  logic imm_unused;
  assign imm_unused = ^in_imm[31:13];
  assign legal      = (in_op <= OP_OR);
`endif

  assign word       = encode(in_op, in_rd, in_rs1, in_rs2, in_imm[12:0]);
  assign hs         = in_valid && (state == ACCEPT);
  assign full       = (count == CAP);
  assign sess_start = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = ACCEPT;
      ACCEPT: begin
        if (hs) begin
          if (full)        state_nxt = DONE;
          else if (!legal) state_nxt = in_last ? DONE : ACCEPT;
          else             state_nxt = WRITE;
        end
      end
      WRITE:   state_nxt = last_p1 ? DONE : ACCEPT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCEPT);
    mem_we   = (state == WRITE);
    busy     = (state == ACCEPT) || (state == WRITE);
    done     = (state == DONE);
  end

  // Pointer and count advance as the WRITE cycle retires, so mem_addr is valid throughout WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= BASE;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      if (sess_start) begin
        mem_addr <= BASE;
        count    <= '0;
        err      <= 1'b0;
      end
      if (hs) begin
        mem_wdata <= word;
        last_p1   <= in_last;
        if (full || !legal) err <= 1'b1;
      end
      if (state == WRITE) begin
        mem_addr <= mem_addr + ADDR_WIDTH'(1);
        count    <= count + (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven sessions plus reset, start-ignore and overflow sequences.
module tb_instr_encoder;

  logic               clk = 1'b0;
  logic               rst, start, in_valid, in_last, sel;
  logic [3:0]         in_op;
  logic [4:0]         in_rd, in_rs1, in_rs2;
  logic signed [31:0] in_imm;

  logic        rdy8, we8, busy8, done8, err8;
  logic [7:0]  addr8;
  logic [31:0] wd8;
  logic [8:0]  cnt8;
  logic        rdy2, we2, busy2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [2:0]  cnt2;

  logic        o_rdy, o_we, o_busy, o_done, o_err;
  logic [7:0]  o_addr;
  logic [31:0] o_wd;
  logic [8:0]  o_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .in_valid(in_valid & ~sel), .in_ready(rdy8),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8), .busy(busy8),
    .done(done8), .count(cnt8), .err(err8)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(start & sel), .in_valid(in_valid & sel), .in_ready(rdy2),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2), .busy(busy2),
    .done(done2), .count(cnt2), .err(err2)
  );

  assign o_rdy  = sel ? rdy2  : rdy8;
  assign o_we   = sel ? we2   : we8;
  assign o_busy = sel ? busy2 : busy8;
  assign o_done = sel ? done2 : done8;
  assign o_err  = sel ? err2  : err8;
  assign o_addr = sel ? {6'b0, addr2} : addr8;
  assign o_wd   = sel ? wd2 : wd8;
  assign o_cnt  = sel ? {6'b0, cnt2} : cnt8;

  typedef struct {
    bit                 new_sess;
    logic [3:0]         op;
    logic [4:0]         rd, rs1, rs2;
    logic signed [31:0] imm;
    bit                 last;
    bit                 we;
    logic [7:0]         addr;
    logic [31:0]        word;
    int                 cnt;
    bit                 err;
    bit                 done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit ns, logic [3:0] op, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, int imm, bit last, bit we, logic [7:0] addr,
                              logic [31:0] word, int cnt, bit err, bit dn);
    vec_t v;
    v.new_sess = ns; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.last = last; v.we = we; v.addr = addr; v.word = word; v.cnt = cnt; v.err = err; v.done = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves start low with the session in ACCEPT at the next negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Handshakes one descriptor; returns at the negedge of the cycle after the handshake.
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic signed [31:0] imm, input bit last);
    int n;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!o_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'b0, o_rdy}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; sel = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

    // Session A: basic program
    tbl.push_back(mk(1, 0, 1, 0, 0,  5, 0, 1, 0, 32'h00500093, 1, 0, 0));
    tbl.push_back(mk(0, 1, 5, 1, 0,  4, 0, 1, 1, 32'h0040A283, 2, 0, 0));
    tbl.push_back(mk(0, 2, 0, 1, 2,  8, 0, 1, 2, 32'h0020A423, 3, 0, 0));
    tbl.push_back(mk(0, 6, 3, 1, 2,  0, 1, 1, 3, 32'h402081B3, 4, 0, 1));
    // Session B: branches, illegal op mid-session, remaining formats
    tbl.push_back(mk(1, 3, 0, 1, 2, -8, 0, 1, 0, 32'hFE208CE3, 1, 0, 0));
    tbl.push_back(mk(0, 4, 0, 1, 2, -8, 0, 1, 1, 32'hFE209CE3, 2, 0, 0));
    tbl.push_back(mk(0, 12, 1, 0, 0, 5, 0, 0, 0, 32'h0,        2, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  5, 0, 1, 2, 32'h00500093, 3, 1, 0));
    tbl.push_back(mk(0, 5, 3, 1, 2,  0, 0, 1, 3, 32'h002081B3, 4, 1, 0));
    tbl.push_back(mk(0, 7, 3, 1, 2,  0, 0, 1, 4, 32'h0020F1B3, 5, 1, 0));
    tbl.push_back(mk(0, 8, 3, 1, 2,  0, 0, 1, 5, 32'h0020E1B3, 6, 1, 0));
    tbl.push_back(mk(0, 0, 2, 0, 0, -1, 0, 1, 6, 32'hFFF00113, 7, 1, 0));
    tbl.push_back(mk(0, 2, 0, 2, 3, -4, 0, 1, 7, 32'hFE312E23, 8, 1, 0));
    tbl.push_back(mk(0, 3, 0, 3, 4, 16, 1, 1, 8, 32'h00418863, 9, 1, 1));
    // Session C: illegal op carrying in_last ends the session
    tbl.push_back(mk(1, 15, 1, 0, 0, 0, 1, 0, 0, 32'h0, 0, 1, 1));
    // Session D: immediate wider than 12 bits
`ifdef IMM_RANGE_CHECK_EN
    tbl.push_back(mk(1, 0, 1, 0, 0, 3000, 1, 0, 0, 32'h0, 0, 1, 1));
`else
    tbl.push_back(mk(1, 0, 1, 0, 0, 3000, 1, 1, 0, 32'hBB800093, 1, 0, 1));
`endif

    repeat (2) @(negedge clk);
    check("rst_we",    {31'b0, o_we},   32'd0);
    check("rst_ready", {31'b0, o_rdy},  32'd0);
    check("rst_busy",  {31'b0, o_busy}, 32'd0);
    check("rst_done",  {31'b0, o_done}, 32'd0);
    check("rst_err",   {31'b0, o_err},  32'd0);
    check("rst_count", {23'b0, o_cnt},  32'd0);
    check("rst_addr",  {24'b0, o_addr}, 32'd0);
    check("rst_wdata", o_wd,            32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].new_sess) pulse_start();
      send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].last);
      check($sformatf("v%0d_we", i), {31'b0, o_we}, {31'b0, tbl[i].we});
      if (tbl[i].we) begin
        check($sformatf("v%0d_addr", i),  {24'b0, o_addr}, {24'b0, tbl[i].addr});
        check($sformatf("v%0d_wdata", i), o_wd, tbl[i].word);
      end
      @(negedge clk);
      check($sformatf("v%0d_count", i), {23'b0, o_cnt}, tbl[i].cnt);
      check($sformatf("v%0d_err", i),   {31'b0, o_err}, {31'b0, tbl[i].err});
      check($sformatf("v%0d_done", i),  {31'b0, o_done}, {31'b0, tbl[i].done});
    end

    // start while ACCEPT must not reset the pointer or count
    pulse_start();
    send(0, 1, 0, 0, 5, 0);
    check("sa_we0", {31'b0, o_we}, 32'd1);
    @(negedge clk);
    pulse_start();
    check("sa_busy",  {31'b0, o_busy}, 32'd1);
    check("sa_count", {23'b0, o_cnt},  32'd1);
    send(0, 2, 0, 0, 7, 1);
    check("sa_we1",   {31'b0, o_we},   32'd1);
    check("sa_addr1", {24'b0, o_addr}, 32'd1);
    check("sa_wdata", o_wd, 32'h00700113);

    // reset asserted during WRITE suppresses the write
    @(negedge clk);
    pulse_start();
    in_op = 4'd0; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'sd5; in_last = 1'b0;
    in_valid = 1'b1;
    check("rw_ready", {31'b0, o_rdy}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("rw_we",    {31'b0, o_we},   32'd0);
    check("rw_busy",  {31'b0, o_busy}, 32'd0);
    check("rw_ready", {31'b0, o_rdy},  32'd0);
    check("rw_wdata", o_wd,            32'd0);
    check("rw_addr",  {24'b0, o_addr}, 32'd0);
    check("rw_count", {23'b0, o_cnt},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rw_we_after",   {31'b0, o_we},   32'd0);
    check("rw_done_after", {31'b0, o_done}, 32'd0);

    // overflow on the 4-word instance
    sel = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      send(4'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k), (k == 4));
      if (k < 4) begin
        check($sformatf("ov%0d_we", k),   {31'b0, o_we},   32'd1);
        check($sformatf("ov%0d_addr", k), {24'b0, o_addr}, 32'(k));
      end else begin
        check("ov4_we", {31'b0, o_we}, 32'd0);
      end
      @(negedge clk);
    end
    check("ov_count", {23'b0, o_cnt},  32'd4);
    check("ov_err",   {31'b0, o_err},  32'd1);
    check("ov_done",  {31'b0, o_done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
